// File: rtl/fifo_async_gen_if.sv
`timescale 1ns/100ps
// Write-side and read-side buses of fifo_async_gen; each group belongs to its own clock domain.
// woverflow/runderflow are present only when FIFO_ERR_FLAGS_EN is defined.
interface fifo_async_gen_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             wfull;
    logic             walmost_full;
    logic [ASIZE:0]   wcount;
    logic             rinc;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             ralmost_empty;
    logic [ASIZE:0]   rcount;
`ifdef FIFO_ERR_FLAGS_EN
    logic             woverflow;
    logic             runderflow;
`endif

    modport master (
        output winc, wdata, rinc,
        input  wfull, walmost_full, wcount, rdata, rempty, ralmost_empty, rcount
`ifdef FIFO_ERR_FLAGS_EN
        , input woverflow, runderflow
`endif
    );

    modport slave (
        input  winc, wdata, rinc,
        output wfull, walmost_full, wcount, rdata, rempty, ralmost_empty, rcount
`ifdef FIFO_ERR_FLAGS_EN
        , output woverflow, runderflow
`endif
    );
endinterface

// File: rtl/fifo_async_gen.sv
`timescale 1ns/100ps
// Dual-clock FIFO, Gray pointers + 2-flop syncs; flags update 3 edges after the far-side op; full/empty drop accesses.
// FIFO_ERR_FLAGS_EN adds sticky woverflow/runderflow. Requires ASIZE >= 2.
module fifo_async_gen #(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic            wclk,
    input  logic            dirclr_n,
    input  logic            rclk,
    input  logic            rrst_n,
    fifo_async_gen_if.slave f
);
    localparam int DEPTH = 1 << ASIZE;
    typedef logic [ASIZE:0] ptr_t;
    localparam ptr_t AFULL_C  = ptr_t'(AFULL_TH);
    localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_TH);

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DSIZE-1:0] mem_q [DEPTH];

    // ---------------- write domain ----------------
    ptr_t wbin_q, wbin_d, wgray_q, wgray_d, rq1_q, rq2_q, wcount_q, wcount_d;
    logic wfull_q, wfull_d, walmost_full_q, walmost_full_d, wen;

    always_comb begin
        wen            = f.winc && !wfull_q;
        wbin_d         = wbin_q + {{ASIZE{1'b0}}, wen};
        wgray_d        = bin2gray(wbin_d);
        // Full when the write pointer is one lap ahead: top two Gray bits inverted.
        wfull_d        = (wgray_d == {~rq2_q[ASIZE:ASIZE-1], rq2_q[ASIZE-2:0]});
        wcount_d       = wbin_d - gray2bin(rq2_q);
        walmost_full_d = (wcount_d >= AFULL_C);
    end

    always_ff @(posedge wclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            wbin_q         <= '0;
            wgray_q        <= '0;
            rq1_q          <= '0;
            rq2_q          <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wcount_q       <= '0;
        end else begin
            wbin_q         <= wbin_d;
            wgray_q        <= wgray_d;
            rq1_q          <= rgray_q;
            rq2_q          <= rq1_q;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wcount_q       <= wcount_d;
        end
    end

    always_ff @(posedge wclk) begin
        if (wen) mem_q[wbin_q[ASIZE-1:0]] <= f.wdata;
    end

    assign f.wfull        = wfull_q;
    assign f.walmost_full = walmost_full_q;
    assign f.wcount       = wcount_q;

    // ---------------- read domain ----------------
    ptr_t rbin_q, rbin_d, rgray_q, rgray_d, wq1_q, wq2_q, rcount_q, rcount_d;
    logic rempty_q, rempty_d, ralmost_empty_q, ralmost_empty_d, ren;

    always_comb begin
        ren             = f.rinc && !rempty_q;
        rbin_d          = rbin_q + {{ASIZE{1'b0}}, ren};
        rgray_d         = bin2gray(rbin_d);
        rempty_d        = (rgray_d == wq2_q);
        rcount_d        = gray2bin(wq2_q) - rbin_d;
        ralmost_empty_d = (rcount_d <= AEMPTY_C);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q          <= '0;
            rgray_q         <= '0;
            wq1_q           <= '0;
            wq2_q           <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rcount_q        <= '0;
        end else begin
            rbin_q          <= rbin_d;
            rgray_q         <= rgray_d;
            wq1_q           <= wgray_q;
            wq2_q           <= wq1_q;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rcount_q        <= rcount_d;
        end
    end

    assign f.rdata         = mem_q[rbin_q[ASIZE-1:0]];
    assign f.rempty        = rempty_q;
    assign f.ralmost_empty = ralmost_empty_q;
    assign f.rcount        = rcount_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic woverflow_q, runderflow_q;

    always_ff @(posedge wclk or negedge dirclr_n) begin
        if (!dirclr_n)                 woverflow_q <= 1'b0;
        else if (f.winc && wfull_q)    woverflow_q <= 1'b1;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n)                   runderflow_q <= 1'b0;
        else if (f.rinc && rempty_q)   runderflow_q <= 1'b1;
    end

    assign f.woverflow  = woverflow_q;
    assign f.runderflow = runderflow_q;
`endif
endmodule

// File: tb/tb_fifo_async_gen.sv
`timescale 1ns/100ps
// Bench for fifo_async_gen: fill/drain vector tables, hand sequences for latency, thresholds and
// reset, then a random-rate stream with swapped clocks checked against a queue model.
module tb_fifo_async_gen;
    localparam int DSIZE = 8, ASIZE = 4, DEPTH = 16, AFULL_TH = 12, AEMPTY_TH = 4;

    logic wclk = 1'b0, rclk = 1'b0, dirclr_n = 1'b0, rrst_n = 1'b0;
    real  whalf = 5.0, rhalf = 8.5;
    always #(whalf) wclk = ~wclk;
    always #(rhalf) rclk = ~rclk;

    int n_chk = 0, n_fail = 0;
    event wr_ev, rd_ev;
    logic [7:0] model_q[$];

    typedef struct {
        logic [7:0] wdata;
        logic       exp_wfull;
        logic       exp_afull;
        logic [4:0] exp_wcount;
    } wvec_t;
    typedef struct {
        logic [7:0] exp_rdata;
        logic [4:0] exp_rcount;
        logic       exp_rempty;
        logic       exp_raempty;
    } rvec_t;
    wvec_t wtab[17];
    rvec_t rtab[16];

    fifo_async_gen_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus();

    fifo_async_gen #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)) dut (
        .wclk(wclk), .dirclr_n(dirclr_n), .rclk(rclk), .rrst_n(rrst_n), .f(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_le(input string name, input int lo, input int hi);
        n_chk++;
        if (!(lo <= hi)) begin
            n_fail++;
            $display("FAIL %s: %0d should be <= %0d at %0t", name, lo, hi, $time);
        end
    endtask

    task automatic wr(input logic [7:0] d);
        bus.winc = 1'b1; bus.wdata = d;
        @(posedge wclk); #1;
        bus.winc = 1'b0;
    endtask

    task automatic rd();
        bus.rinc = 1'b1;
        @(posedge rclk); #1;
        bus.rinc = 1'b0;
    endtask

    task automatic do_reset();
        bus.winc = 1'b0; bus.rinc = 1'b0;
        dirclr_n = 1'b0; rrst_n = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_wcount", bus.wcount, 0);
        chk("rst_rcount", bus.rcount, 0);
        chk("rst_rempty", bus.rempty, 1);
        chk("rst_wfull", bus.wfull, 0);
        chk("rst_walmost_full", bus.walmost_full, 0);
        chk("rst_ralmost_empty", bus.ralmost_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_woverflow", bus.woverflow, 0);
        chk("rst_runderflow", bus.runderflow, 0);
`endif
        @(negedge wclk); #0.2;
        dirclr_n = 1'b1; rrst_n = 1'b1;
        repeat (2) @(posedge rclk);
        @(posedge wclk); #1;
    endtask

    initial begin
        bus.winc = 1'b0; bus.rinc = 1'b0; bus.wdata = '0;

        for (int i = 0; i < 16; i++) begin
            wtab[i].wdata      = 8'(i);
            wtab[i].exp_wcount = 5'(i + 1);
            wtab[i].exp_wfull  = (i == DEPTH - 1);
            wtab[i].exp_afull  = (i + 1 >= AFULL_TH);
        end
        wtab[16].wdata = 8'hAA; wtab[16].exp_wcount = 5'd16;
        wtab[16].exp_wfull = 1'b1; wtab[16].exp_afull = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rtab[k].exp_rdata   = 8'(k);
            rtab[k].exp_rcount  = 5'(15 - k);
            rtab[k].exp_rempty  = (k == 15);
            rtab[k].exp_raempty = (15 - k <= AEMPTY_TH);
        end

        do_reset();

        // Fill to full plus one dropped write; rempty latency measured alongside.
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    bus.winc = 1'b1; bus.wdata = wtab[i].wdata;
                    @(posedge wclk);
                    if (i == 0) -> wr_ev;
                    #1;
                    chk("fill_wfull", bus.wfull, wtab[i].exp_wfull);
                    chk("fill_wcount", bus.wcount, wtab[i].exp_wcount);
                    chk("fill_walmost_full", bus.walmost_full, wtab[i].exp_afull);
`ifdef FIFO_ERR_FLAGS_EN
                    chk("fill_woverflow", bus.woverflow, (i == 16));
`endif
                end
                bus.winc = 1'b0;
            end
            begin
                int lat;
                lat = 0;
                @(wr_ev);
                do begin @(posedge rclk); #1; lat++; end while (bus.rempty && lat < 8);
                chk("rempty_latency", lat, 3);
            end
        join
`ifdef FIFO_ERR_FLAGS_EN
        repeat (3) @(posedge wclk); #1;
        chk("woverflow_sticky", bus.woverflow, 1);
`endif
        repeat (4) @(posedge rclk); #1;
        chk("synced_rcount", bus.rcount, 16);
        chk("synced_ralmost_empty", bus.ralmost_empty, 0);

        // Drain; the dropped 0xAA must never appear, and wfull release latency is measured.
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    chk("drain_rdata", bus.rdata, rtab[k].exp_rdata);
                    bus.rinc = 1'b1;
                    @(posedge rclk);
                    if (k == 0) -> rd_ev;
                    #1;
                    chk("drain_rcount", bus.rcount, rtab[k].exp_rcount);
                    chk("drain_rempty", bus.rempty, rtab[k].exp_rempty);
                    chk("drain_ralmost_empty", bus.ralmost_empty, rtab[k].exp_raempty);
                end
                bus.rinc = 1'b0;
            end
            begin
                int lat;
                lat = 0;
                @(rd_ev);
                do begin @(posedge wclk); #1; lat++; end while (bus.wfull && lat < 8);
                chk("wfull_release_latency", lat, 3);
            end
        join
        repeat (4) @(posedge wclk); #1;
        chk("drained_wcount", bus.wcount, 0);
        chk("drained_walmost_full", bus.walmost_full, 0);

`ifdef FIFO_ERR_FLAGS_EN
        chk("runderflow_clear", bus.runderflow, 0);
        rd();
        chk("runderflow_set", bus.runderflow, 1);
        chk("underflow_rcount", bus.rcount, 0);
        chk("underflow_rempty", bus.rempty, 1);
`endif
        do_reset();

        // Thresholds: 12 writes then 8 reads.
        for (int i = 0; i < 12; i++) begin
            wr(8'(8'h30 + i));
            chk("thr_wcount", bus.wcount, i + 1);
            chk("thr_walmost_full", bus.walmost_full, (i + 1 >= AFULL_TH));
        end
        repeat (4) @(posedge rclk); #1;
        chk("thr_rcount", bus.rcount, 12);
        for (int k = 0; k < 8; k++) begin
            chk("thr_rdata", bus.rdata, 8'h30 + k);
            rd();
            chk("thr_rcount_rd", bus.rcount, 11 - k);
            chk("thr_ralmost_empty", bus.ralmost_empty, (11 - k <= AEMPTY_TH));
        end
        repeat (4) @(posedge wclk); #1;
        chk("thr_wcount_after", bus.wcount, 4);
        chk("thr_walmost_full_after", bus.walmost_full, 0);

        // Reset in the middle of traffic, then the first word after it must be the head.
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
        do_reset();
        wr(8'h55);
        repeat (4) @(posedge rclk); #1;
        chk("post_rst_rempty", bus.rempty, 0);
        chk("post_rst_rcount", bus.rcount, 1);
        chk("post_rst_rdata", bus.rdata, 8'h55);

        // Random-rate stream of 100 words with the clock ratio reversed.
        whalf = 8.5; rhalf = 5.0;
        do_reset();
        model_q.delete();
        fork
            begin
                int sent, wcyc;
                logic full_s;
                sent = 0; wcyc = 0;
                while (sent < 100 && wcyc < 3000) begin
                    full_s    = bus.wfull;
                    bus.winc  = ($urandom_range(0, 3) != 0);
                    bus.wdata = 8'(sent);
                    @(posedge wclk); #1;
                    wcyc++;
                    if (bus.winc && !full_s) begin
                        model_q.push_back(bus.wdata);
                        sent++;
                    end
                    chk_le("wcount_ge_fill", model_q.size(), int'(bus.wcount));
                    chk_le("wcount_le_depth", int'(bus.wcount), DEPTH);
                end
                bus.winc = 1'b0;
                chk("stream_sent", sent, 100);
            end
            begin
                int got, rcyc;
                logic empty_s;
                logic [7:0] d;
                got = 0; rcyc = 0;
                while (got < 100 && rcyc < 6000) begin
                    empty_s  = bus.rempty;
                    d        = bus.rdata;
                    bus.rinc = ($urandom_range(0, 2) != 0);
                    @(posedge rclk); #1;
                    rcyc++;
                    if (bus.rinc && !empty_s) begin
                        chk("stream_model_nonempty", (model_q.size() != 0), 1);
                        if (model_q.size() != 0) chk("stream_data", d, model_q.pop_front());
                        got++;
                    end
                    chk_le("rcount_le_fill", int'(bus.rcount), model_q.size());
                end
                bus.rinc = 1'b0;
                chk("stream_received", got, 100);
            end
        join
        repeat (4) @(posedge rclk); #1;
        chk("stream_end_rempty", bus.rempty, 1);
        chk("stream_end_model_empty", model_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
